// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply sequencer computing
// x^n mod (2^255 - 19). It drives an external modular-multiply unit over
// a mm_req / mm_done handshake and owns the exponent shift register,
// bit counter, accumulator and FSM.
//
// Optional feature: define MOD_EXP_SKIP_LZ_EN to skip the exponent's
// leading zeros in a SCAN state. That makes run time depend on the
// exponent. The default build always performs N squarings.
//
// Handshake: mm_req is a one-cycle pulse issued in SQR/MUL. mm_a/mm_b are
// held from the request cycle through the mm_done cycle. The design
// consumes mm_done/mm_result only while waiting (SQR_W/MUL_W). A pulse
// at any other time is ignored.
module mod_exp_ctrl #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] n,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         mm_req,
  output logic [N-1:0] mm_a,
  output logic [N-1:0] mm_b,
  input  logic         mm_done,
  input  logic [N-1:0] mm_result,
  output logic [2:0]   dbg_state
);

  localparam int CW = $clog2(N) + 1;

`ifdef MOD_EXP_SKIP_LZ_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQR   = 3'd1,
    SQR_W = 3'd2,
    MUL   = 3'd3,
    MUL_W = 3'd4,
    FIN   = 3'd5,
    SCAN  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SQR   = 3'd1,
    SQR_W = 3'd2,
    MUL   = 3'd3,
    MUL_W = 3'd4,
    FIN   = 3'd5
  } state_t;
`endif

  state_t         state, state_nxt;
  logic [N-1:0]   acc, exp_r, base_r, result_r;
  logic [CW-1:0]  cnt;

  // Datapath strobes produced by the FSM.
  logic ld_start, ld_acc_mm, ld_acc_base, shift, ld_result;
  logic cnt_last;

  // A shift in this cycle consumes the last exponent bit.
  assign cnt_last  = (cnt == CW'(1));
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, handshake outputs and datapath strobes.
  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    mm_req      = 1'b0;
    mm_a        = '0;
    mm_b        = '0;
    ld_start    = 1'b0;
    ld_acc_mm   = 1'b0;
    ld_acc_base = 1'b0;
    shift       = 1'b0;
    ld_result   = 1'b0;
    result      = result_r;
    case (state)
      IDLE: begin
        if (start) begin
          ld_start = 1'b1;
`ifdef MOD_EXP_SKIP_LZ_EN
          state_nxt = SCAN;
`else
          state_nxt = SQR;
`endif
        end
      end
`ifdef MOD_EXP_SKIP_LZ_EN
      SCAN: begin
        shift = 1'b1;
        if (exp_r[N-1]) begin
          // The leading one replaces the square/multiply of 1 by base.
          ld_acc_base = 1'b1;
          state_nxt   = cnt_last ? FIN : SQR;
        end else if (cnt_last) begin
          state_nxt = FIN;
        end
      end
`endif
      SQR: begin
        mm_req    = 1'b1;
        mm_a      = acc;
        mm_b      = acc;
        state_nxt = SQR_W;
      end
      SQR_W: begin
        mm_a = acc;
        mm_b = acc;
        if (mm_done) begin
          ld_acc_mm = 1'b1;
          if (exp_r[N-1]) begin
            state_nxt = MUL;
          end else begin
            shift     = 1'b1;
            state_nxt = cnt_last ? FIN : SQR;
          end
        end
      end
      MUL: begin
        mm_req    = 1'b1;
        mm_a      = acc;
        mm_b      = base_r;
        state_nxt = MUL_W;
      end
      MUL_W: begin
        mm_a = acc;
        mm_b = base_r;
        if (mm_done) begin
          ld_acc_mm = 1'b1;
          shift     = 1'b1;
          state_nxt = cnt_last ? FIN : SQR;
        end
      end
      FIN: begin
        // Present the accumulator in the done cycle itself; the register
        // holds it afterwards until the next completion.
        done      = 1'b1;
        ld_result = 1'b1;
        result    = acc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, exponent, counter, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      exp_r    <= '0;
      base_r   <= '0;
      cnt      <= '0;
      result_r <= '0;
    end else begin
      if (ld_start) begin
        base_r <= x;
        exp_r  <= n;
        acc    <= N'(1);
        cnt    <= CW'(N);
      end
      if (ld_acc_mm)   acc <= mm_result;
      if (ld_acc_base) acc <= base_r;
      if (shift) begin
        exp_r <= exp_r << 1;
        cnt   <= cnt - CW'(1);
      end
      if (ld_result) result_r <= acc;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural mm unit (configurable latency,
// optional spurious mm_done pulses), a right-to-left modular power model
// and a scoreboard queue of expected results.
module tb_mod_exp_ctrl;

  localparam int N = 256;
  localparam logic [N-1:0] P =
    256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;
  localparam int BOUND = 20000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         start;
  logic [N-1:0] x_in, n_in;
  logic         busy, done, mm_req, mm_done;
  logic [N-1:0] result, mm_a, mm_b, mm_result;
  logic [2:0]   dbg_state;

  mod_exp_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x_in), .n(n_in),
    .busy(busy), .done(done), .result(result),
    .mm_req(mm_req), .mm_a(mm_a), .mm_b(mm_b),
    .mm_done(mm_done), .mm_result(mm_result), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  int req_count = 0;
  int exp_ops, exp_scan;
  int lat_min = 3, lat_max = 3;
  bit spur_en = 0;
  bit pending = 0, stale = 0;
  int countdown = 0;
  logic [N-1:0] cap_a, cap_b;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] pr;
    pr = (2*N)'(a) * (2*N)'(b);
    pr = pr % (2*N)'(P);
    return pr[N-1:0];
  endfunction

  // Right-to-left binary powering: independent of the DUT's bit order.
  function automatic logic [N-1:0] model_pow(input logic [N-1:0] xx, input logic [N-1:0] nn);
    logic [N-1:0] r, b;
    r = N'(1);
    b = xx;
    for (int i = 0; i < N; i++) begin
      if (nn[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic int msb_idx(input logic [N-1:0] nn);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (nn[i]) k = i;
    return k;
  endfunction

  function automatic int ops_f(input logic [N-1:0] nn);
`ifdef MOD_EXP_SKIP_LZ_EN
    if (nn == '0) return 0;
    return msb_idx(nn) + $countones(nn) - 1;
`else
    return N + $countones(nn);
`endif
  endfunction

  function automatic int scan_f(input logic [N-1:0] nn);
`ifdef MOD_EXP_SKIP_LZ_EN
    if (nn == '0) return N;
    return N - msb_idx(nn);
`else
    return (nn == nn) ? 0 : 0;
`endif
  endfunction

  function automatic logic [N-1:0] rand_below_p();
    logic [N-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    if (v >= P) v = v - P;
    return v;
  endfunction

  // ---------------- behavioural mm unit ----------------
  initial begin
    mm_done   = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      if (!rst_n && pending) stale = 1;
      if (mm_req) req_count++;
      if (pending) begin
        if (!stale) begin
          check("mm_a_stable", mm_a, cap_a);
          check("mm_b_stable", mm_b, cap_b);
          check("mm_req_while_pending", N'(mm_req), N'(0));
        end
        countdown--;
        if (countdown == 0) begin
          mm_done   = 1'b1;
          mm_result = mulmod(cap_a, cap_b);
          pending   = 0;
          stale     = 0;
        end else begin
          mm_done = 1'b0;
        end
      end else if (mm_req) begin
        cap_a     = mm_a;
        cap_b     = mm_b;
        pending   = 1;
        countdown = $urandom_range(lat_max, lat_min);
        // Spurious pulse in the request (SQR/MUL) cycle.
        mm_done   = spur_en && ($urandom_range(0, 1) == 1);
        mm_result = rand_below_p();
      end else if (spur_en && !busy && ($urandom_range(0, 3) == 0)) begin
        mm_done   = 1'b1;
        mm_result = rand_below_p();
      end else begin
        mm_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [N-1:0] xx, input logic [N-1:0] nn);
    exp_q.push_back(model_pow(xx, nn));
    exp_ops  = ops_f(nn);
    exp_scan = scan_f(nn);
    @(negedge clk);
    x_in      = xx;
    n_in      = nn;
    start     = 1'b1;
    req_count = 0;
  endtask

  // Entered at the negedge of the cycle in which start is sampled.
  task automatic wait_finish(input string tag, input bit hold, output logic [N-1:0] r);
    int cyc;
    bit fixed;
    fixed = (lat_min == lat_max);
    @(negedge clk);
    check({tag, "_busy_rise"}, N'(busy), N'(1));
    if (!hold) start = 1'b0;
    cyc = 1;
    while (!done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
    end
    r = result;
    if (!done) begin
      check({tag, "_timeout"}, N'(done), N'(1));
      return;
    end
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_busy_in_done"}, N'(busy), N'(1));
    check({tag, "_mm_ops"}, N'(req_count), N'(exp_ops));
    if (fixed)
      check({tag, "_latency"}, N'(cyc), N'(exp_scan + 1 + exp_ops * (lat_min + 1)));
    @(negedge clk);
    check({tag, "_done_pulse"}, N'(done), N'(0));
    check({tag, "_busy_fall"}, N'(busy), N'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [N-1:0] r, r1, xr, nr;
    int w;
    start = 1'b0;
    x_in  = '0;
    n_in  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   N'(busy),   N'(0));
    check("rst_done",   N'(done),   N'(0));
    check("rst_mm_req", N'(mm_req), N'(0));
    check("rst_mm_a",   mm_a,       N'(0));
    check("rst_mm_b",   mm_b,       N'(0));
    check("rst_result", result,     N'(0));
    check("rst_state",  N'(dbg_state), N'(0));
    rst_n = 1'b1;

    // Known answers with fixed latency 3.
    launch(N'(3), N'(5));
    wait_finish("x3_n5", 0, r);
    check("x3_n5_kat", r, N'(243));

    launch(N'(2), P - N'(1));
    wait_finish("fermat2", 0, r);
    check("fermat2_kat", r, N'(1));

    launch(N'(9), P - N'(2));
    wait_finish("inv9", 0, r);
    check("inv9_product", mulmod(N'(9), r), N'(1));

    launch(N'(0), N'(0));
    wait_finish("x0_n0", 0, r);
    check("x0_n0_kat", r, N'(1));

    launch(N'(7), N'(0));
    wait_finish("x7_n0", 0, r);
    check("x7_n0_kat", r, N'(1));

    // Reset in the wait after the first multiply of x=5, n=0xFF.
    launch(N'(5), N'(255));
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(mm_req && mm_b == N'(5) && mm_a != mm_b) && w < BOUND) begin
      @(negedge clk);
      w++;
    end
    check("rst_mul_found", N'(mm_req && mm_b == N'(5)), N'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",   N'(busy),   N'(0));
    check("mid_rst_done",   N'(done),   N'(0));
    check("mid_rst_mm_req", N'(mm_req), N'(0));
    check("mid_rst_mm_a",   mm_a,       N'(0));
    check("mid_rst_mm_b",   mm_b,       N'(0));
    check("mid_rst_result", result,     N'(0));
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (pending && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("stray_done_busy",   N'(busy), N'(0));
    check("stray_done_result", result,   N'(0));

    launch(N'(5), N'(3));
    wait_finish("x5_n3", 0, r);
    check("x5_n3_kat", r, N'(125));

    // start held across done: second run accepted the cycle after done.
    launch(N'(3), N'(5));
    wait_finish("hold_a", 1, r1);
    exp_q.push_back(model_pow(x_in, n_in));
    req_count = 0;
    wait_finish("hold_b", 0, r);
    check("hold_same_result", r, r1);

    // Random operands, random latency 1..20, spurious mm_done pulses.
    spur_en = 1;
    lat_min = 1;
    lat_max = 20;
    for (int i = 0; i < 4; i++) begin
      xr = rand_below_p();
      nr = rand_below_p();
      if (i == 3) nr = nr >> $urandom_range(200, 8);
      launch(xr, nr);
      wait_finish("rand", 0, r);
    end
    repeat (8) @(negedge clk);
    check("result_held_idle", result, r);
    spur_en = 0;
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
